// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder for the MIPS memory stage.
// A valid/ready request is latched in IDLE and waits WAIT_CYCLES cycles in WAIT.
// Byte/half/word storage is committed on the edge that enters RESP, and a
// one-cycle response follows.
// Optional build macro: DMEM_MISALIGN_TRAP_EN. When it is defined, misaligned
// half/word accesses are flagged on rsp_err and are not performed.
//
// state  | meaning
// IDLE   | ready for a request
// WAIT   | counting down wait states
// RESP   | response pulse, access already committed
module dmem_responder #(
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_we,
  input  logic [1:0]  i_req_size,
  input  logic        i_req_signed,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  output logic        o_rsp_valid,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_err,
  output logic        o_busy
);

  localparam int         NWORDS   = 2 ** (ADDR_W - 2);
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t              r_state;
  logic [3:0]          r_cnt;
  logic                r_we;
  logic [1:0]          r_size;
  logic                r_signed;
  logic [ADDR_W-1:0]   r_addr;
  logic [31:0]         r_wdata;
  logic                r_rsp_valid;
  logic [31:0]         r_rsp_rdata;
  logic                r_rsp_err;
  logic [31:0]         r_mem [NWORDS];

  logic                w_in_idle;
  logic                w_commit;
  logic                w_we;
  logic [1:0]          w_size;
  logic                w_signed;
  logic [ADDR_W-1:0]   w_addr;
  logic [31:0]         w_wdata;
  logic [ADDR_W-3:0]   w_idx;
  logic [31:0]         w_rd_word;
  logic [31:0]         w_byte_sh;
  logic [31:0]         w_half_sh;
  logic                w_mis;
  logic [3:0]          w_be;
  logic [31:0]         w_wrep;
  logic [31:0]         w_load;
  logic                w_unused;

  assign w_unused = &{1'b0, i_req_addr[31:ADDR_W]};

  assign w_in_idle   = (r_state == S_IDLE);
  assign o_req_ready = w_in_idle;
  assign o_busy      = !w_in_idle;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_rdata = r_rsp_rdata;
  assign o_rsp_err   = r_rsp_err;

  // With zero wait states the commit happens on the accepting edge, so the
  // access fields come straight from the request port in IDLE.
  assign w_we     = w_in_idle ? i_req_we                   : r_we;
  assign w_size   = w_in_idle ? i_req_size                 : r_size;
  assign w_signed = w_in_idle ? i_req_signed               : r_signed;
  assign w_addr   = w_in_idle ? i_req_addr[ADDR_W-1:0]     : r_addr;
  assign w_wdata  = w_in_idle ? i_req_wdata                : r_wdata;

  assign w_commit = i_rst_n &&
                    ((w_in_idle && i_req_valid && (WAIT_CYCLES == 0)) ||
                     ((r_state == S_WAIT) && (r_cnt == 4'd0)));

  assign w_idx     = w_addr[ADDR_W-1:2];
  assign w_rd_word = r_mem[w_idx];
  assign w_byte_sh = w_rd_word >> {w_addr[1:0], 3'b000};
  assign w_half_sh = w_rd_word >> {w_addr[1], 4'b0000};

`ifdef DMEM_MISALIGN_TRAP_EN
  assign w_mis = ((w_size == 2'b01) && w_addr[0]) ||
                 (w_size[1] && (w_addr[1:0] != 2'b00));
`else
  assign w_mis = 1'b0;
`endif

  // Lane enables, replicated store data and extended load data
  always_comb begin
    w_be   = 4'b1111;
    w_wrep = w_wdata;
    w_load = w_rd_word;
    case (w_size)
      2'b00: begin
        w_be   = 4'b0001 << w_addr[1:0];
        w_wrep = {4{w_wdata[7:0]}};
        w_load = {{24{w_signed & w_byte_sh[7]}}, w_byte_sh[7:0]};
      end
      2'b01: begin
        w_be   = w_addr[1] ? 4'b1100 : 4'b0011;
        w_wrep = {2{w_wdata[15:0]}};
        w_load = {{16{w_signed & w_half_sh[15]}}, w_half_sh[15:0]};
      end
      default: ;
    endcase
  end

  // Storage is not reset; contents survive reset
  always_ff @(posedge i_clk) begin
    if (w_commit && w_we && !w_mis) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wrep[8*b +: 8];
      end
    end
  end

  // Request FSM with latched fields and registered response outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= 4'd0;
      r_we        <= 1'b0;
      r_size      <= 2'b00;
      r_signed    <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= 32'd0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 32'd0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_req_valid) begin
            r_we     <= i_req_we;
            r_size   <= i_req_size;
            r_signed <= i_req_signed;
            r_addr   <= i_req_addr[ADDR_W-1:0];
            r_wdata  <= i_req_wdata;
            r_cnt    <= CNT_INIT;
            r_state  <= (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_cnt == 4'd0) r_state <= S_RESP;
          else               r_cnt   <= r_cnt - 4'd1;
        end
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
      if (w_commit) begin
        r_rsp_valid <= 1'b1;
        r_rsp_rdata <= (w_we || w_mis) ? 32'd0 : w_load;
        r_rsp_err   <= w_mis;
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Testbench for dmem_responder: a WAIT_CYCLES=1 instance checked against a
// byte-array reference model, plus a WAIT_CYCLES=0 instance for throughput
// and address wrap.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        v1, v0;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic        ready1, rsp_valid1, err1, busy1;
  logic [31:0] rdata1;
  logic        ready0, rsp_valid0, err0, busy0;
  logic [31:0] rdata0;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem_m [256];

  always #5 clk = ~clk;

  dmem_responder #(.ADDR_W(8), .WAIT_CYCLES(1)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(v1), .o_req_ready(ready1),
    .i_req_we(req_we), .i_req_size(req_size), .i_req_signed(req_signed),
    .i_req_addr(req_addr), .i_req_wdata(req_wdata),
    .o_rsp_valid(rsp_valid1), .o_rsp_rdata(rdata1), .o_rsp_err(err1), .o_busy(busy1)
  );

  dmem_responder #(.ADDR_W(8), .WAIT_CYCLES(0)) dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(v0), .o_req_ready(ready0),
    .i_req_we(req_we), .i_req_size(req_size), .i_req_signed(req_signed),
    .i_req_addr(req_addr), .i_req_wdata(req_wdata),
    .o_rsp_valid(rsp_valid0), .o_rsp_rdata(rdata0), .o_rsp_err(err0), .o_busy(busy0)
  );

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Reference: byte-addressed memory, address taken modulo 256
  task automatic model(input logic we, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd,
                       output logic [31:0] er, output logic ee);
    int ab, n, base;
    bit mis;
    logic [31:0] v;
    ab   = int'(a % 256);
    n    = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    mis  = (ab % n) != 0;
    base = ab - (ab % n);
    er   = 32'd0;
    ee   = 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
    if (mis) ee = 1'b1;
`else
    if (mis) ee = 1'b0;
`endif
    if (!ee) begin
      if (we) begin
        for (int i = 0; i < n; i++) mem_m[base + i] = wd[8*i +: 8];
      end else begin
        v = 32'd0;
        for (int i = 0; i < n; i++) v = v | ({24'd0, mem_m[base + i]} << (8 * i));
        if (sg && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
        er = v;
      end
    end
  endtask

  // One full transaction on the WAIT_CYCLES=1 instance; called right after an edge
  task automatic xact(input logic we, input logic [1:0] sz, input logic sg,
                      input logic [31:0] a, input logic [31:0] wd,
                      output logic [31:0] got);
    logic [31:0] er;
    logic ee;
    model(we, sz, sg, a, wd, er, ee);
    chk1("ready_idle", ready1, 1'b1);
    req_we = we; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
    v1 = 1'b1;
    @(posedge clk); #1;
    v1 = 1'b0;
    req_addr = $urandom; req_wdata = $urandom; req_size = 2'($urandom); req_we = 1'($urandom);
    chk1("ready_wait", ready1, 1'b0);
    chk1("busy_wait", busy1, 1'b1);
    chk1("rsp_early", rsp_valid1, 1'b0);
    @(posedge clk); #1;
    chk1("rsp_valid", rsp_valid1, 1'b1);
    chk32("rdata", rdata1, er);
    chk1("rsp_err", err1, ee);
    chk1("ready_resp", ready1, 1'b0);
    got = rdata1;
    @(posedge clk); #1;
    chk1("rsp_pulse", rsp_valid1, 1'b0);
    chk1("ready_back", ready1, 1'b1);
    chk1("busy_idle", busy1, 1'b0);
    chk32("rdata_hold", rdata1, er);
  endtask

  initial begin
    logic [31:0] got;
    rst_n = 1'b0; v1 = 1'b0; v0 = 1'b0;
    req_we = 1'b0; req_size = 2'b00; req_signed = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk1("rst_ready", ready1, 1'b1);
    chk1("rst_rsp_valid", rsp_valid1, 1'b0);
    chk32("rst_rdata", rdata1, 32'd0);
    chk1("rst_err", err1, 1'b0);
    chk1("rst_busy", busy1, 1'b0);
    chk1("rst_ready0", ready0, 1'b1);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Fill all storage so the model knows every byte
    for (int w = 0; w < 64; w++) xact(1'b1, 2'b10, 1'b0, 32'(4 * w), $urandom, got);

    // Word store/load
    xact(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, got);
    xact(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, got);
    chk32("word_load", got, 32'hDEADBEEF);

    // Byte lanes and extension
    xact(1'b1, 2'b10, 1'b0, 32'h20, 32'h0, got);
    xact(1'b1, 2'b00, 1'b0, 32'h21, 32'h80, got);
    xact(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, got);
    chk32("byte_word", got, 32'h0000_8000);
    xact(1'b0, 2'b00, 1'b1, 32'h21, 32'h0, got);
    chk32("byte_signed", got, 32'hFFFF_FF80);
    xact(1'b0, 2'b00, 1'b0, 32'h21, 32'h0, got);
    chk32("byte_unsigned", got, 32'h0000_0080);

    // Halfword upper lane
    xact(1'b1, 2'b10, 1'b0, 32'h30, 32'h0000_5A3C, got);
    xact(1'b1, 2'b01, 1'b0, 32'h32, 32'h0000_8001, got);
    xact(1'b0, 2'b01, 1'b1, 32'h32, 32'h0, got);
    chk32("half_signed", got, 32'hFFFF_8001);
    xact(1'b0, 2'b10, 1'b0, 32'h30, 32'h0, got);
    chk32("half_word", got, 32'h8001_5A3C);

    // Misalignment
    xact(1'b1, 2'b10, 1'b0, 32'h10, 32'h1234_5678, got);
    xact(1'b0, 2'b10, 1'b0, 32'h13, 32'h0, got);
`ifdef DMEM_MISALIGN_TRAP_EN
    chk32("mis_load", got, 32'h0);
`else
    chk32("mis_load", got, 32'h1234_5678);
`endif
    xact(1'b1, 2'b01, 1'b0, 32'h11, 32'h0000_ABCD, got);
    xact(1'b1, 2'b11, 1'b0, 32'h16, 32'hCAFE_0001, got);
    xact(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, got);
    xact(1'b0, 2'b10, 1'b0, 32'h14, 32'h0, got);

    // Randomized mix; full 32-bit addresses also exercise wrap
    for (int t = 0; t < 80; t++)
      xact(1'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom, got);

    // Reset during WAIT aborts the store
    xact(1'b1, 2'b10, 1'b0, 32'h40, 32'h0, got);
    req_we = 1'b1; req_size = 2'b10; req_signed = 1'b0; req_addr = 32'h40; req_wdata = 32'hAAAA_5555;
    v1 = 1'b1;
    @(posedge clk); #1;
    v1 = 1'b0;
    chk1("abort_busy_before", busy1, 1'b1);
    rst_n = 1'b0;
    #1;
    chk1("abort_ready", ready1, 1'b1);
    chk1("abort_busy", busy1, 1'b0);
    chk1("abort_rsp", rsp_valid1, 1'b0);
    @(posedge clk); #1;
    chk1("abort_rsp_later", rsp_valid1, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk1("abort_rsp_after", rsp_valid1, 1'b0);
    xact(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, got);
    chk32("abort_mem", got, 32'h0);

    // WAIT_CYCLES=0: wrap store at 0x100, then back-to-back loads at 0x000
    req_we = 1'b1; req_size = 2'b10; req_signed = 1'b0; req_addr = 32'h100; req_wdata = 32'hCAFE_F00D;
    chk1("w0_ready", ready0, 1'b1);
    v0 = 1'b1;
    @(posedge clk); #1;
    v0 = 1'b0;
    chk1("w0_rsp", rsp_valid0, 1'b1);
    chk32("w0_store_rdata", rdata0, 32'h0);
    chk1("w0_ready_resp", ready0, 1'b0);
    @(posedge clk); #1;
    chk1("w0_rsp_pulse", rsp_valid0, 1'b0);
    chk1("w0_ready_back", ready0, 1'b1);
    req_we = 1'b0; req_addr = 32'h000;
    v0 = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      chk1("b2b_rsp", rsp_valid0, 1'(k % 2));
      chk1("b2b_ready", ready0, 1'((k + 1) % 2));
      if (k % 2 == 1) chk32("wrap_load", rdata0, 32'hCAFE_F00D);
    end
    v0 = 1'b0;
    @(posedge clk); #1;
    chk1("w0_idle", busy0, 1'b0);
    chk1("w0_err", err0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Memory-side responder for the pipelined MIPS CPU's data port. It accepts load/store requests over a valid/ready handshake, holds the word-organised data storage, and performs byte, halfword and word accesses with byte-lane write enables. It sign- or zero-extends load data and returns one response per request after a programmable number of wait states. It replaces the bare single-cycle data RAM when the memory stage must tolerate multi-cycle latency; the CPU stalls its memory stage on `busy`.

## Interface
- `ADDR_W`, 8: byte-address bits decoded. Storage is 2^ADDR_W bytes (2^(ADDR_W-2) 32-bit words). Legal range 4..16.
- `WAIT_CYCLES`, 1: wait states between acceptance and response. Legal range 0..15.

- `clk` in 1: single clock. All state changes on the rising edge.
- `rst` in 1: **asynchronous, active-low reset.**
- `req_valid` in 1: request present.
- `req_ready` out 1: responder can accept a request.
- `req_we` in 1: 1 = store, 0 = load.
- `req_size` in 2: access size. 00 = byte, 01 = half, 10 = word, 11 = treated as word.
- `req_signed` in 1: sign-extend load data (ignored for word and for stores).
- `req_addr` in 32: byte address. Bits above ADDR_W-1 are ignored.
- `req_wdata` in 32: store data, right-justified.
- `rsp_valid` out 1: one-cycle response pulse, issued for loads and stores.
- `rsp_rdata` out 32: extended load data. 0 for stores.
- `rsp_err` out 1: misaligned access flag (see Configuration).
- `busy` out 1: request accepted and response not yet delivered.

## Operation
- **FSM states:** IDLE, WAIT, RESP.
- **IDLE:**
  - `req_ready`=1.
  - On `req_valid` the responder latches we, size, signed, addr and wdata.
  - Next state is WAIT when WAIT_CYCLES>0 (counter loaded with WAIT_CYCLES-1), otherwise RESP.
- **WAIT:**
  - Counter decrements each cycle.
  - When the counter reaches 0, next state is RESP.
  - New requests are ignored (`req_ready`=0).
- **Commit:** the memory access happens on the edge that enters RESP.
  - Stores write the selected lanes.
  - Loads capture the word and extend it into `rsp_rdata`.
- **RESP:**
  - `rsp_valid`=1 for exactly one cycle, then IDLE unconditionally.
  - There is no response back-pressure.
- **Lane mapping (little-endian):**
  - Byte: lane `addr[1:0]`, data bits [7:0].
  - Half: lanes {addr[1],0} and {addr[1],1}, data bits [15:0].
  - Word: all four lanes.
- **Load extension:**
  - Byte/half with `req_signed`=1 replicate the MSB of the extracted field.
  - Otherwise the field is zero-filled.
- `rsp_rdata` and `rsp_err` hold their values until the next commit.
- **Wrap-around:** `addr` modulo 2^ADDR_W. No out-of-range error exists.
- **Storage:** not cleared by reset; contents survive reset.

## Timing
- **Reset values (while `rst`=0):** state IDLE, `req_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, `busy`=0.
- **Reset mid-operation:** the request is aborted.
  - A store not yet committed leaves memory unchanged.
  - No `rsp_valid` is produced for the aborted request.
- **Latency:** request accepted at edge E.
  - `rsp_valid` is high in the cycle after edge E+WAIT_CYCLES.
  - `req_ready` returns high after edge E+WAIT_CYCLES+1.
- **Throughput:** one request per WAIT_CYCLES+2 cycles.
- `busy` = (state≠IDLE).
- `req_ready` = (state==IDLE), combinational from state.
- **Handshake rules:**
  - `req_valid` may drop without acceptance.
  - Request fields matter only in the accepting cycle.

## Configuration
- **`DMEM_MISALIGN_TRAP_EN` defined:**
  - Misaligned means half with addr[0]=1, or word with addr[1:0]≠0.
  - A misaligned request is accepted and timed normally.
  - At commit, memory is unchanged, `rsp_rdata`=0 and `rsp_err`=1.
  - Aligned requests set `rsp_err`=0.
- **Not defined:**
  - Low address bits are forced to alignment: half ignores addr[0], word ignores addr[1:0].
  - `rsp_err` is tied to 0.

## Test plan
- **Word store/load, WAIT_CYCLES=1:**
  - Store 0xDEADBEEF @0x10, then load word @0x10.
  - Required: `rsp_rdata`=0xDEADBEEF, `rsp_valid` in the cycle after edge E+1, `req_ready` low for 2 cycles after each acceptance.
- **Byte lanes and extension:**
  - Store byte 0x80 @0x21 over word 0x00000000.
  - Load word @0x20 → 0x00008000.
  - Load signed byte @0x21 → 0xFFFFFF80.
  - Load unsigned byte @0x21 → 0x00000080.
- **Halfword, upper lane:**
  - Store half 0x8001 @0x32.
  - Signed half load @0x32 → 0xFFFF8001.
  - Word load @0x30 → 0x8001xxxx, with the low half unchanged.
- **Misalignment:** word load @0x13 after 0x12345678 was stored @0x10.
  - Macro off: `rsp_rdata`=0x12345678, `rsp_err`=0.
  - Macro on: `rsp_rdata`=0, `rsp_err`=1, and memory unchanged after a misaligned store.
- **WAIT_CYCLES=0 and wrap:**
  - Back-to-back requests are accepted every 2 cycles.
  - A store to 0x100 with ADDR_W=8 is read back at 0x000.
- **Reset in WAIT:** assert `rst`=0 during WAIT of a store 0xAAAA5555 @0x40 (previously 0).
  - Required: no `rsp_valid`, `req_ready`=1 immediately.
  - A load @0x40 after release returns 0.
